// File: rtl/sha256_spi_master.sv
// SPI mode-3 master issuing 16-bit {we, addr, data} command frames to the SHA-256 slave port.
// One command at a time; the 16 MISO bits of each frame come back with a one-cycle strobe.
module sha256_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int SS_SETUP = 4,
  parameter int SS_HOLD  = 4,
  parameter int GAP      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_we,
  input  logic [6:0]  i_addr,
  input  logic [7:0]  i_wdata,
  output logic        o_rsp_valid,
  output logic [15:0] o_rsp_frame,
  output logic [7:0]  o_rdata,
  output logic        o_busy,
  output logic        o_spi_sck,
  output logic        o_spi_ss_n,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   tx_sr;
  logic [15:0]   rx_sr;

  assign o_rdata = o_rsp_frame[7:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      o_ready     <= 1'b1;
      o_busy      <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_frame <= '0;
      o_spi_sck   <= 1'b1;
      o_spi_ss_n  <= 1'b1;
      o_spi_mosi  <= 1'b0;
    end else begin
      o_rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_valid && o_ready) begin
            tx_sr      <= {i_we, i_addr, i_wdata};
            bit_cnt    <= '0;
            cnt        <= '0;
            o_spi_ss_n <= 1'b0;
            o_ready    <= 1'b0;
            o_busy     <= 1'b1;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == CW'(SS_SETUP - 1)) begin
            cnt        <= '0;
            o_spi_sck  <= 1'b0;
            o_spi_mosi <= tx_sr[15];
            tx_sr      <= {tx_sr[14:0], 1'b0};
            state      <= ST_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            cnt <= '0;
            if (!o_spi_sck) begin
              // Rising edge: the slave's bit has been stable for a full low half.
              o_spi_sck <= 1'b1;
              rx_sr     <= {rx_sr[14:0], i_spi_miso};
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd15) begin
                state <= ST_HOLD;
              end
            end else begin
              o_spi_sck  <= 1'b0;
              o_spi_mosi <= tx_sr[15];
              tx_sr      <= {tx_sr[14:0], 1'b0};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == CW'(SS_HOLD - 1)) begin
            cnt         <= '0;
            o_spi_ss_n  <= 1'b1;
            o_spi_mosi  <= 1'b0;
            o_rsp_frame <= rx_sr;
            o_rsp_valid <= 1'b1;
            state       <= ST_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == CW'(GAP - 1)) begin
            cnt     <= '0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_spi_master.sv
// Directed bench for sha256_spi_master: a default instance and a CLK_DIV=6 instance,
// each watched by an SPI slave model that records edge timing and MOSI bits and drives MISO.
module tb_sha256_spi_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid [2];
  logic        we;
  logic [6:0]  addr;
  logic [7:0]  wdata;
  logic        ready [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_frame [2];
  logic [7:0]  rdata [2];
  logic        busy [2];
  logic        sck [2];
  logic        ss_n [2];
  logic        mosi [2];
  logic        miso [2];

  always #5 clk = ~clk;

  sha256_spi_master u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[0]), .o_ready(ready[0]),
    .i_we(we), .i_addr(addr), .i_wdata(wdata), .o_rsp_valid(rsp_valid[0]),
    .o_rsp_frame(rsp_frame[0]), .o_rdata(rdata[0]), .o_busy(busy[0]),
    .o_spi_sck(sck[0]), .o_spi_ss_n(ss_n[0]), .o_spi_mosi(mosi[0]), .i_spi_miso(miso[0])
  );

  sha256_spi_master #(.CLK_DIV(6)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[1]), .o_ready(ready[1]),
    .i_we(we), .i_addr(addr), .i_wdata(wdata), .o_rsp_valid(rsp_valid[1]),
    .o_rsp_frame(rsp_frame[1]), .o_rdata(rdata[1]), .o_busy(busy[1]),
    .o_spi_sck(sck[1]), .o_spi_ss_n(ss_n[1]), .o_spi_mosi(mosi[1]), .i_spi_miso(miso[1])
  );

  // Edge counter and acceptance timestamps (edge number of the accepting clock edge).
  int cyc = 0;
  int acc_time [2];
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst_n && valid[i] && ready[i]) acc_time[i] = cyc;
    end
  end

  // Slave model / monitor, sampled on the falling clock edge.
  int          falls [2], rises [2], first_fall [2], first_rise [2], last_rise [2];
  int          ss_fall [2], ss_rise [2], ss_fall_cnt [2], rsp_cnt [2], rsp_time [2];
  int          ready_time [2], bad_tog [2];
  logic [15:0] mosi_cap [2];
  logic [15:0] miso_word [2];
  logic        mon_clr [2];
  logic        prev_sck [2], prev_ss [2], prev_ready [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mon_clr[i]) begin
        falls[i] = 0; rises[i] = 0; first_fall[i] = -1; first_rise[i] = -1; last_rise[i] = -1;
        ss_fall[i] = -1; ss_rise[i] = -1; ss_fall_cnt[i] = 0; rsp_cnt[i] = 0; rsp_time[i] = -1;
        ready_time[i] = -1; bad_tog[i] = 0; mosi_cap[i] = '0; miso[i] = 1'b0;
      end else if (rst_n) begin
        if (prev_sck[i] && !sck[i]) begin
          miso[i] = miso_word[i][15 - (falls[i] % 16)];
          falls[i]++;
          if (first_fall[i] < 0) first_fall[i] = cyc;
        end
        if (!prev_sck[i] && sck[i]) begin
          rises[i]++;
          if (first_rise[i] < 0) first_rise[i] = cyc;
          last_rise[i] = cyc;
          mosi_cap[i] = {mosi_cap[i][14:0], mosi[i]};
        end
        if ((sck[i] !== prev_sck[i]) && ss_n[i] && prev_ss[i]) bad_tog[i]++;
        if (prev_ss[i] && !ss_n[i]) begin ss_fall[i] = cyc; ss_fall_cnt[i]++; end
        if (!prev_ss[i] && ss_n[i]) ss_rise[i] = cyc;
        if (rsp_valid[i]) begin rsp_cnt[i]++; rsp_time[i] = cyc; end
        if (!prev_ready[i] && ready[i]) ready_time[i] = cyc;
      end
      prev_sck[i] = sck[i];
      prev_ss[i] = ss_n[i];
      prev_ready[i] = ready[i];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Spec cycle numbering: accept edge = 0, a value set at edge N is "at cycle N+1".
  function automatic int rel(input int i, input int t);
    return t - acc_time[i] + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon(input int i);
    mon_clr[i] = 1'b1;
    @(negedge clk);
    #1;
    mon_clr[i] = 1'b0;
  endtask

  task automatic wait_ready(input int i);
    int b = 0;
    while (!ready[i] && b < 400) begin tick(); b++; end
  endtask

  task automatic send(input int i, input logic w, input logic [6:0] a, input logic [7:0] d);
    we = w; addr = a; wdata = d; valid[i] = 1'b1;
    wait_ready(i);
    tick();
    valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, input int n, input int budget);
    int b = 0;
    while (rsp_cnt[i] < n && b < budget) begin tick(); b++; end
    chk("rsp_arrived", 32'(rsp_cnt[i]), 32'(n));
  endtask

  task automatic settle(input int i);
    wait_ready(i);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int rise1;
    int b;
    valid[0] = 1'b0; valid[1] = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    mon_clr[0] = 1'b1; mon_clr[1] = 1'b1;
    miso_word[0] = '0; miso_word[1] = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_sck", 32'(sck[0]), 32'd1);
    chk("rst_ss_n", 32'(ss_n[0]), 32'd1);
    chk("rst_mosi", 32'(mosi[0]), 32'd0);
    chk("rst_ready", 32'(ready[0]), 32'd1);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_frame", 32'(rsp_frame[0]), 32'h0000);
    chk("rst_u1_sck", 32'(sck[1]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon(1);

    // Write frame, default timing
    miso_word[0] = 16'hC3E1;
    clear_mon(0);
    send(0, 1'b1, 7'h05, 8'hA5);
    wait_rsp(0, 1, 300);
    settle(0);
    chk("wr_mosi", 32'(mosi_cap[0]), 32'h85A5);
    chk("wr_falls", 32'(falls[0]), 32'd16);
    chk("wr_rises", 32'(rises[0]), 32'd16);
    chk("wr_ss_fall", 32'(rel(0, ss_fall[0])), 32'd1);
    chk("wr_first_fall", 32'(rel(0, first_fall[0])), 32'd5);
    chk("wr_first_rise", 32'(rel(0, first_rise[0])), 32'd9);
    chk("wr_last_rise", 32'(rel(0, last_rise[0])), 32'd129);
    chk("wr_ss_rise", 32'(rel(0, ss_rise[0])), 32'd133);
    chk("wr_rsp_time", 32'(rel(0, rsp_time[0])), 32'd133);
    chk("wr_rsp_pulses", 32'(rsp_cnt[0]), 32'd1);
    chk("wr_ready_time", 32'(rel(0, ready_time[0])), 32'd137);
    chk("wr_rsp_frame", 32'(rsp_frame[0]), 32'hC3E1);
    chk("wr_rdata", 32'(rdata[0]), 32'hE1);
    chk("wr_no_stray_sck", 32'(bad_tog[0]), 32'd0);

    // Read frame
    miso_word[0] = 16'h4037;
    clear_mon(0);
    send(0, 1'b0, 7'h40, 8'h00);
    wait_rsp(0, 1, 300);
    chk("rd_mosi", 32'(mosi_cap[0]), 32'h4000);
    chk("rd_rsp_frame", 32'(rsp_frame[0]), 32'h4037);
    chk("rd_rdata", 32'(rdata[0]), 32'h37);
    settle(0);

    // Back-to-back with i_valid held; second command's fields must be used
    miso_word[0] = 16'hBEEF;
    clear_mon(0);
    we = 1'b1; addr = 7'h11; wdata = 8'h22; valid[0] = 1'b1;
    wait_ready(0);
    tick();
    we = 1'b0; addr = 7'h2A; wdata = 8'h5C;
    wait_rsp(0, 1, 300);
    chk("b2b_mosi1", 32'(mosi_cap[0]), 32'h9122);
    rise1 = ss_rise[0];
    b = 0;
    while (ss_fall_cnt[0] < 2 && b < 300) begin tick(); b++; end
    valid[0] = 1'b0;
    chk("b2b_second_start", 32'(ss_fall_cnt[0]), 32'd2);
    chk("b2b_gap", 32'(ss_fall[0] - rise1), 32'd5);
    wait_rsp(0, 2, 300);
    chk("b2b_mosi2", 32'(mosi_cap[0]), 32'h2A5C);
    chk("b2b_rsp_frame", 32'(rsp_frame[0]), 32'hBEEF);
    chk("b2b_rises", 32'(rises[0]), 32'd32);
    settle(0);
    repeat (20) tick();
    chk("b2b_no_third", 32'(ss_fall_cnt[0]), 32'd2);
    chk("b2b_no_stray_sck", 32'(bad_tog[0]), 32'd0);

    // Request pulsed while busy is ignored
    clear_mon(0);
    send(0, 1'b1, 7'h33, 8'h0F);
    repeat (40) tick();
    we = 1'b0; addr = 7'h7F; wdata = 8'hFF; valid[0] = 1'b1;
    repeat (2) tick();
    valid[0] = 1'b0;
    wait_rsp(0, 1, 300);
    settle(0);
    repeat (20) tick();
    chk("busy_frames", 32'(ss_fall_cnt[0]), 32'd1);
    chk("busy_rsps", 32'(rsp_cnt[0]), 32'd1);
    chk("busy_mosi", 32'(mosi_cap[0]), 32'hB30F);

    // Reset in the middle of a frame
    clear_mon(0);
    send(0, 1'b1, 7'h7E, 8'h81);
    b = 0;
    while (rises[0] < 7 && b < 200) begin tick(); b++; end
    chk("mid_rises_before", 32'(rises[0]), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_sck", 32'(sck[0]), 32'd1);
    chk("mid_ss_n", 32'(ss_n[0]), 32'd1);
    chk("mid_mosi", 32'(mosi[0]), 32'd0);
    chk("mid_ready", 32'(ready[0]), 32'd1);
    chk("mid_busy", 32'(busy[0]), 32'd0);
    chk("mid_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("mid_rsp_frame", 32'(rsp_frame[0]), 32'h0000);
    repeat (3) tick();
    chk("mid_no_rsp", 32'(rsp_cnt[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    miso_word[0] = 16'h1234;
    clear_mon(0);
    send(0, 1'b1, 7'h7E, 8'h81);
    wait_rsp(0, 1, 300);
    chk("post_mosi", 32'(mosi_cap[0]), 32'hFE81);
    chk("post_rsp_frame", 32'(rsp_frame[0]), 32'h1234);
    chk("post_falls", 32'(falls[0]), 32'd16);
    settle(0);

    // CLK_DIV = 6 instance
    miso_word[1] = 16'hA55A;
    clear_mon(1);
    send(1, 1'b1, 7'h05, 8'hA5);
    wait_rsp(1, 1, 400);
    settle(1);
    chk("div6_mosi", 32'(mosi_cap[1]), 32'h85A5);
    chk("div6_falls", 32'(falls[1]), 32'd16);
    chk("div6_rises", 32'(rises[1]), 32'd16);
    chk("div6_first_fall", 32'(rel(1, first_fall[1])), 32'd5);
    chk("div6_first_rise", 32'(rel(1, first_rise[1])), 32'd11);
    chk("div6_last_rise", 32'(rel(1, last_rise[1])), 32'd191);
    chk("div6_ss_rise", 32'(rel(1, ss_rise[1])), 32'd195);
    chk("div6_ready_time", 32'(rel(1, ready_time[1])), 32'd199);
    chk("div6_rsp_frame", 32'(rsp_frame[1]), 32'hA55A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha256_spi_master.md
Name: sha256_spi_master

Overview:
SPI mode-3 master that drives the 16-bit command frames understood by the SHA-256 SPI slave port. It serves as the host side for bench/system use, for example an on-chip controller or FPGA bridge loading message bytes and reading digest bytes. The host issues one command at a time over a valid/ready handshake. The block serialises {we, addr[6:0], data[7:0]} MSB-first on MOSI, captures 16 MISO bits in the same frame, and returns them with a one-cycle response strobe.

Parameters:
CLK_DIV, 4, SCK half-period in i_clk cycles; legal range >=4, needed because the slave samples through a 3-flop synchroniser.
SS_SETUP, 4, i_clk cycles between SS_n falling and the first SCK falling edge; legal range >=1.
SS_HOLD, 4, i_clk cycles between the last SCK rising edge and SS_n rising; legal range >=1.
GAP, 4, i_clk cycles SS_n stays high before the next frame may start; legal range >=1.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_valid  in  1  command request
o_ready  out  1  block can accept a command; high only in IDLE
i_we  in  1  frame bit 15: 1 = write, 0 = read
i_addr  in  7  frame bits 14..8
i_wdata  in  8  frame bits 7..0; sent for reads too
o_rsp_valid  out  1  one-cycle pulse: frame complete
o_rsp_frame  out  16  MISO bits captured, first bit in [15]
o_rdata  out  8  o_rsp_frame[7:0]
o_busy  out  1  high in any state other than IDLE
o_spi_sck  out  1  SPI clock, idles high
o_spi_ss_n  out  1  slave select, active low
o_spi_mosi  out  1  master-out data
i_spi_miso  in  1  master-in data

Behaviour:
- Reset values: o_spi_sck=1, o_spi_ss_n=1, o_spi_mosi=0, o_ready=1, o_busy=0, o_rsp_valid=0, o_rsp_frame=0. All outputs are registered.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - Accept a command when i_valid && o_ready.
  - Latch the shift register {i_we, i_addr, i_wdata}. Clear the bit counter (0..15) and the divider counter.
  - o_spi_ss_n goes low on the next cycle. Go to SETUP.
- SETUP:
  - Hold SS_SETUP cycles with SCK high, then go to SHIFT.
- SHIFT: 16 bits, each made of a low half then a high half, CLK_DIV cycles each.
  - On the cycle SCK falls, MOSI takes the current MSB of the shift register. This is mode 3: data changes on the falling edge.
  - On the cycle SCK rises, sample i_spi_miso into the LSB of the capture register, shift left, and increment the bit counter.
  - After the 16th rising edge, SCK stays high. Go to HOLD.
- HOLD:
  - Hold SS_HOLD cycles.
  - Then set o_spi_ss_n=1, load o_rsp_frame from the capture register, and pulse o_rsp_valid for one cycle in that same cycle.
  - o_spi_mosi returns to 0. Go to GAP.
- GAP:
  - Hold GAP cycles with SS_n high, then go to IDLE (o_ready=1).
- Timing with default parameters, accept edge = cycle 0:
  - SS_n low at cycle 1.
  - SCK falling edges at 5+8k and rising edges at 9+8k, for k=0..15.
  - Last rise at cycle 129.
  - SS_n high and o_rsp_valid at cycle 133.
  - o_ready at cycle 137.
  - Minimum frame-to-frame period is 137 cycles.
- i_valid while o_ready=0 is ignored; no queueing. A held request is accepted on the first o_ready cycle. Inputs are sampled only at acceptance.
- o_rsp_frame and o_rdata hold their value until the next o_rsp_valid.
- Exactly 16 falling and 16 rising SCK edges occur per frame. SCK never toggles while SS_n is high.
- Read semantics: the captured frame is whatever the slave shifted out. Pairing read data with the correct address is the host's responsibility; the block does no interpretation.
- Asynchronous reset mid-frame:
  - All outputs return to reset values immediately.
  - No o_rsp_valid is produced. The partial frame is discarded.
  - After release, the block is in IDLE.

Test Plan:
- Reset check: assert i_rst_n=0 -> sck=1, ss_n=1, mosi=0, ready=1, busy=0, rsp_valid=0, rsp_frame=0x0000.
- Write frame: we=1, addr=0x05, wdata=0xA5 -> bits sampled on SCK rising edges = 0x85A5. Exactly 16 falling and 16 rising edges, SCK period 8 clk. SS_n low from cycle 1 to cycle 132. rsp_valid single pulse at cycle 133.
- Read frame: we=0, addr=0x40, MISO model drives 0x4037 (changing on SCK fall) -> MOSI = 0x4000 (wdata=0), o_rsp_frame=0x4037, o_rdata=0x37.
- Back-to-back: i_valid held high with a second command queued -> second SS_n fall occurs exactly GAP+1 cycles after the first SS_n rise. SS_n high >=4 cycles in between. Second command's fields are used.
- Reset mid-frame: assert reset after the 7th SCK rising edge -> outputs at idle values immediately, no rsp_valid, prior rsp_frame cleared to 0. A new command after release completes normally.
- Busy ignore and parameter check: pulse i_valid during SHIFT -> ignored, no second frame. Rerun the write test with CLK_DIV=6 -> SCK period 12 clk, last rise at cycle 5+15*12+6=191.
